// File: rtl/pe_pkg.sv
// pe_pkg: shared state encoding and saturation classification for the processing element
package pe_pkg;
  typedef enum logic {IDLE, ACCUM} pe_state_e;
  // Classifies an (ACC_WIDTH+1)-bit sum from its two top bits: {overflowed, toward_min}
  function automatic logic [1:0] sat_kind(input logic sgn, input logic ext_msb, input logic msb);
    return sgn ? {ext_msb ^ msb, ext_msb} : {ext_msb, 1'b0};
  endfunction
endpackage

// File: rtl/processing_element_acc_if.sv
// processing_element_acc_if: operand stream, echo stream and result chain of one systolic PE
interface processing_element_acc_if #(
  parameter int WIDTH = 16,
  parameter int ACC_WIDTH = 40
);
  logic                 in_valid;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_last;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_a;
  logic [WIDTH-1:0]     out_b;
  logic                 out_last;
  logic                 in_c_valid;
  logic [ACC_WIDTH-1:0] in_c;
  logic                 out_c_valid;
  logic [ACC_WIDTH-1:0] out_c;
  modport master (
    output in_valid, in_a, in_b, in_last, in_c_valid, in_c,
    input  out_valid, out_a, out_b, out_last, out_c_valid, out_c
  );
  modport slave (
    input  in_valid, in_a, in_b, in_last, in_c_valid, in_c,
    output out_valid, out_a, out_b, out_last, out_c_valid, out_c
  );
endinterface

// File: rtl/pe_mult_pipe.sv
// pe_mult_pipe: MUL_LAT-deep multiplier pipeline carrying valid/last tags with each product
module pe_mult_pipe
  import pe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MUL_LAT = 2,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               last_i,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               last_o,
  output logic               busy_o
);
  localparam int PW = 2 * WIDTH;
  logic signed [PW-1:0] prod_s;
  logic [PW-1:0]        prod_u;
  logic [PW-1:0]        prod_d;
  logic [MUL_LAT-1:0]   v_q;
  logic [MUL_LAT-1:0]   l_q;
  logic [PW-1:0]        p_q [MUL_LAT];
  // Signed and unsigned products kept in separate nets so signedness never leaks between them
  always_comb begin
    prod_s = $signed(a_i) * $signed(b_i);
    prod_u = a_i * b_i;
    prod_d = SIGNED != 0 ? prod_s : prod_u;
  end
  // First stage registers the raw product with its tags
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q[0] <= 1'b0;
      l_q[0] <= 1'b0;
      p_q[0] <= '0;
    end else begin
      v_q[0] <= valid_i;
      l_q[0] <= last_i;
      p_q[0] <= prod_d;
    end
  end
  for (genvar g = 1; g < MUL_LAT; g++) begin : g_stage
    // Remaining stages are plain delay registers for product and tags
    always_ff @(posedge clk) begin
      if (!reset) begin
        v_q[g] <= 1'b0;
        l_q[g] <= 1'b0;
        p_q[g] <= '0;
      end else begin
        v_q[g] <= v_q[g-1];
        l_q[g] <= l_q[g-1];
        p_q[g] <= p_q[g-1];
      end
    end
  end
  assign valid_o = v_q[MUL_LAT-1];
  assign last_o  = l_q[MUL_LAT-1];
  assign prod_o  = p_q[MUL_LAT-1];
  assign busy_o  = |v_q;
endmodule

// File: rtl/processing_element_acc.sv
// processing_element_acc: systolic MAC cell with operand echo, tile accumulator and result chain
module processing_element_acc
  import pe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int MUL_LAT = 2,
  parameter int SIGNED = 1,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  processing_element_acc_if.slave   p,
  output logic                      busy,
  output logic                      sat_hit,
  output logic                      err_ovf
);
  localparam int PW = 2 * WIDTH;
  localparam logic [ACC_WIDTH-1:0] MAX_V = SIGNED != 0 ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] MIN_V = SIGNED != 0 ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};
  logic                 m_valid;
  logic                 m_last;
  logic                 m_busy;
  logic [PW-1:0]        m_prod;
  logic [ACC_WIDTH:0]   prod_x;
  logic [ACC_WIDTH:0]   acc_x;
  logic [ACC_WIDTH:0]   sum_x;
  logic [1:0]           kind;
  logic [ACC_WIDTH-1:0] sum_d;
  logic                 done;
  logic                 sat_d;
  pe_state_e            state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] res_q;
  logic                 pend_q;
  logic [ACC_WIDTH-1:0] oc_q;
  logic                 ocv_q;
  logic                 sat_q;
  logic                 ovf_q;
  logic                 ov_q;
  logic [WIDTH-1:0]     oa_q;
  logic [WIDTH-1:0]     ob_q;
  logic                 ol_q;
  pe_mult_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .SIGNED(SIGNED)) u_mult (
    .clk(clk), .reset(reset),
    .valid_i(p.in_valid), .a_i(p.in_a), .b_i(p.in_b), .last_i(p.in_last),
    .valid_o(m_valid), .prod_o(m_prod), .last_o(m_last), .busy_o(m_busy)
  );
  // One guard bit above the accumulator exposes carry/overflow for clamping
  always_comb begin
    prod_x = {{(ACC_WIDTH+1-PW){SIGNED != 0 && m_prod[PW-1]}}, m_prod};
    acc_x  = {SIGNED != 0 && acc_q[ACC_WIDTH-1], acc_q};
    sum_x  = acc_x + prod_x;
    kind   = sat_kind(SIGNED != 0, sum_x[ACC_WIDTH], sum_x[ACC_WIDTH-1]);
    sum_d  = SATURATE != 0 && kind[1] ? (kind[0] ? MIN_V : MAX_V) : sum_x[ACC_WIDTH-1:0];
    done   = m_valid && m_last;
    sat_d  = SATURATE != 0 && m_valid && kind[1];
  end
  // Operands and tags pass east/south one cycle later regardless of anything else
  always_ff @(posedge clk) begin
    if (!reset) begin
      ov_q <= 1'b0;
      oa_q <= '0;
      ob_q <= '0;
      ol_q <= 1'b0;
    end else begin
      ov_q <= p.in_valid;
      oa_q <= p.in_a;
      ob_q <= p.in_b;
      ol_q <= p.in_last;
    end
  end
  // Tile FSM plus result chain: upstream wins, then pending result, else a fresh result bypasses straight out
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      res_q   <= '0;
      pend_q  <= 1'b0;
      oc_q    <= '0;
      ocv_q   <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (m_valid) begin
        acc_q   <= m_last ? '0 : sum_d;
        state_q <= m_last ? IDLE : ACCUM;
      end
      if (sat_d) sat_q <= 1'b1;
      if (p.in_c_valid) begin
        oc_q  <= p.in_c;
        ocv_q <= 1'b1;
        if (done && pend_q) ovf_q <= 1'b1;
        if (done && !pend_q) begin
          res_q  <= sum_d;
          pend_q <= 1'b1;
        end
      end else if (pend_q) begin
        oc_q   <= res_q;
        ocv_q  <= 1'b1;
        pend_q <= done;
        if (done) res_q <= sum_d;
      end else if (done) begin
        oc_q  <= sum_d;
        ocv_q <= 1'b1;
        res_q <= sum_d;
      end else begin
        ocv_q <= 1'b0;
      end
    end
  end
  assign p.out_valid   = ov_q;
  assign p.out_a       = oa_q;
  assign p.out_b       = ob_q;
  assign p.out_last    = ol_q;
  assign p.out_c_valid = ocv_q;
  assign p.out_c       = oc_q;
  assign busy          = m_busy || state_q == ACCUM || pend_q;
  assign sat_hit       = sat_q;
  assign err_ovf       = ovf_q;
endmodule

// File: tb/tb_processing_element_acc.sv
// tb_processing_element_acc: directed checks of echo, tiling, result chain, saturation and reset
module tb_processing_element_acc;
  logic clk = 1'b0;
  logic reset;
  logic busy0, sat0, ovf0, busy1, sat1, ovf1, busy2, sat2, ovf2;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  processing_element_acc_if #(.WIDTH(16), .ACC_WIDTH(40)) if0 ();
  processing_element_acc_if #(.WIDTH(16), .ACC_WIDTH(32)) if1 ();
  processing_element_acc_if #(.WIDTH(16), .ACC_WIDTH(32)) if2 ();
  processing_element_acc #(.WIDTH(16), .ACC_WIDTH(40), .MUL_LAT(2), .SIGNED(1), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .p(if0.slave), .busy(busy0), .sat_hit(sat0), .err_ovf(ovf0));
  processing_element_acc #(.WIDTH(16), .ACC_WIDTH(32), .MUL_LAT(2), .SIGNED(1), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .p(if1.slave), .busy(busy1), .sat_hit(sat1), .err_ovf(ovf1));
  processing_element_acc #(.WIDTH(16), .ACC_WIDTH(32), .MUL_LAT(2), .SIGNED(1), .SATURATE(0)) dut2 (
    .clk(clk), .reset(reset), .p(if2.slave), .busy(busy2), .sat_hit(sat2), .err_ovf(ovf2));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drv0(input logic v, input logic [15:0] a, input logic [15:0] b, input logic l);
    if0.in_valid = v;
    if0.in_a = a;
    if0.in_b = b;
    if0.in_last = l;
  endtask
  task automatic chain0(input logic v, input logic [39:0] c);
    if0.in_c_valid = v;
    if0.in_c = c;
  endtask
  task automatic drv_sat(input logic v, input logic l);
    if1.in_valid = v;
    if1.in_a = v ? 16'h7FFF : 16'h0;
    if1.in_b = v ? 16'h7FFF : 16'h0;
    if1.in_last = l;
    if2.in_valid = v;
    if2.in_a = v ? 16'h7FFF : 16'h0;
    if2.in_b = v ? 16'h7FFF : 16'h0;
    if2.in_last = l;
  endtask
  initial begin
    reset = 1'b0;
    drv0(0, 0, 0, 0);
    chain0(0, 0);
    drv_sat(0, 0);
    if1.in_c_valid = 1'b0;
    if1.in_c = '0;
    if2.in_c_valid = 1'b0;
    if2.in_c = '0;
    step();
    step();
    chk("rst_ocv", if0.out_c_valid, 0);
    chk("rst_oc", if0.out_c, 0);
    chk("rst_ov", if0.out_valid, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_sat", sat0, 0);
    // signed tile (2,3),(4,5),(-1,7); first operand offered as reset releases
    reset = 1'b1;
    drv0(1, 16'd2, 16'd3, 0);
    step();
    chk("echo_v0", if0.out_valid, 1);
    chk("echo_a0", if0.out_a, 2);
    chk("echo_b0", if0.out_b, 3);
    drv0(1, 16'd4, 16'd5, 0);
    step();
    chk("echo_a1", if0.out_a, 4);
    chk("echo_b1", if0.out_b, 5);
    drv0(1, 16'hFFFF, 16'd7, 1);
    step();
    chk("echo_a2", if0.out_a, 16'hFFFF);
    chk("echo_l2", if0.out_last, 1);
    chk("t1_ocv_t1", if0.out_c_valid, 0);
    chk("t1_busy", busy0, 1);
    drv0(0, 0, 0, 0);
    step();
    chk("t1_ocv_t2", if0.out_c_valid, 0);
    chk("echo_idle", if0.out_valid, 0);
    step();
    chk("t1_ocv_t3", if0.out_c_valid, 1);
    chk("t1_oc", if0.out_c, 19);
    step();
    chk("t1_ocv_t4", if0.out_c_valid, 0);
    chk("t1_busy_end", busy0, 0);
    // back-to-back one-product tiles
    drv0(1, 16'd1, 16'd1, 1);
    step();
    drv0(1, 16'd2, 16'd2, 1);
    step();
    drv0(0, 0, 0, 0);
    chk("b2b_ocv_t2", if0.out_c_valid, 0);
    step();
    chk("b2b_ocv0", if0.out_c_valid, 1);
    chk("b2b_oc0", if0.out_c, 1);
    step();
    chk("b2b_ocv1", if0.out_c_valid, 1);
    chk("b2b_oc1", if0.out_c, 4);
    step();
    chk("b2b_ocv_end", if0.out_c_valid, 0);
    chk("b2b_ovf", ovf0, 0);
    // upstream chain has priority over a local result of 19
    drv0(1, 16'd19, 16'd1, 1);
    step();
    drv0(0, 0, 0, 0);
    step();
    chain0(1, 40'hAA);
    step();
    chk("ch_oc0", if0.out_c, 40'hAA);
    chk("ch_ocv0", if0.out_c_valid, 1);
    step();
    chk("ch_oc1", if0.out_c, 40'hAA);
    step();
    chk("ch_oc2", if0.out_c, 40'hAA);
    chain0(0, 0);
    step();
    chk("ch_ocv_local", if0.out_c_valid, 1);
    chk("ch_oc_local", if0.out_c, 19);
    step();
    chk("ch_ocv_end", if0.out_c_valid, 0);
    chk("ch_ovf", ovf0, 0);
    // chain held busy while two local tiles finish: second result is dropped
    drv0(1, 16'd5, 16'd5, 1);
    chain0(1, 40'h55);
    step();
    drv0(1, 16'd6, 16'd6, 1);
    step();
    drv0(0, 0, 0, 0);
    step();
    step();
    chk("ovf_set", ovf0, 1);
    chk("ovf_oc_up", if0.out_c, 40'h55);
    step();
    step();
    chk("ovf_oc_up2", if0.out_c, 40'h55);
    chain0(0, 0);
    step();
    chk("ovf_ocv_first", if0.out_c_valid, 1);
    chk("ovf_oc_first", if0.out_c, 25);
    step();
    chk("ovf_ocv_end", if0.out_c_valid, 0);
    chk("ovf_sticky", ovf0, 1);
    chk("ovf_busy", busy0, 0);
    // reset between 2nd and 3rd operand of an open tile
    drv0(1, 16'd1, 16'd2, 0);
    step();
    drv0(1, 16'd3, 16'd4, 0);
    step();
    drv0(0, 0, 0, 0);
    reset = 1'b0;
    step();
    chk("mrst_busy", busy0, 0);
    chk("mrst_ocv", if0.out_c_valid, 0);
    chk("mrst_ovf", ovf0, 0);
    chk("mrst_ov", if0.out_valid, 0);
    reset = 1'b1;
    drv0(1, 16'd3, 16'd3, 1);
    step();
    drv0(0, 0, 0, 0);
    chk("mrst_ocv1", if0.out_c_valid, 0);
    step();
    chk("mrst_ocv2", if0.out_c_valid, 0);
    step();
    chk("mrst_ocv3", if0.out_c_valid, 1);
    chk("mrst_oc", if0.out_c, 9);
    step();
    chk("mrst_ocv_end", if0.out_c_valid, 0);
    // saturate vs wrap on 32-bit accumulators: 3 x 0x7FFF^2
    drv_sat(1, 0);
    step();
    drv_sat(1, 0);
    step();
    drv_sat(1, 1);
    step();
    drv_sat(0, 0);
    step();
    step();
    chk("sat_ocv", if1.out_c_valid, 1);
    chk("sat_oc", if1.out_c, 32'h7FFFFFFF);
    chk("sat_hit", sat1, 1);
    chk("wrap_ocv", if2.out_c_valid, 1);
    chk("wrap_oc", if2.out_c, 32'hBFFD0003);
    chk("wrap_nosat", sat2, 0);
    chk("sat0_clear", sat0, 0);
    step();
    chk("sat_sticky", sat1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/processing_element_acc.md
PROCESSING_ELEMENT_ACC -- requirements
Module: processing_element_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter ACC_WIDTH, default 40, accumulator/result width; ACC_WIDTH >= 2*WIDTH.
REQ-003 SHALL have parameter MUL_LAT, default 2, multiplier pipeline depth; MUL_LAT >= 1.
REQ-004 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL have parameter SATURATE, default 0: 1 = clamp accumulator, 0 = wrap modulo 2^ACC_WIDTH.
REQ-006 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have reset  in  1  synchronous, active-low reset.
REQ-008 SHALL have in_valid  in  1; in_a  in  WIDTH (west); in_b  in  WIDTH (north); in_last  in  1 (final operand pair of tile).
REQ-009 SHALL have out_valid  out  1; out_a  out  WIDTH (east); out_b  out  WIDTH (south); out_last  out  1.
REQ-010 SHALL have in_c_valid  in  1; in_c  in  ACC_WIDTH (result chain from upstream PE).
REQ-011 SHALL have out_c_valid  out  1; out_c  out  ACC_WIDTH (result chain downstream).
REQ-012 SHALL have busy  out  1; sat_hit  out  1 (sticky); err_ovf  out  1 (sticky).

Function
REQ-013 out_valid/out_a/out_b/out_last SHALL equal in_valid/in_a/in_b/in_last delayed exactly 1 cycle, unconditionally.
REQ-014 Product SHALL be in_a*in_b (2*WIDTH bits, sign- or zero-extended per SIGNED to ACC_WIDTH), emerging MUL_LAT cycles after sampling, tagged with its valid and last.
REQ-015 Pipeline stages with valid=0 SHALL NOT modify the accumulator.
REQ-016 States: IDLE (acc=0, no tile open) and ACCUM; IDLE->ACCUM on valid product without last; ACCUM->IDLE on valid product with last; valid+last in IDLE is a one-product tile.
REQ-017 On valid product with last: result register <= acc+product, result_pending <= 1, acc <= 0 same edge; next product (following cycle) SHALL start a fresh tile with no bubble.
REQ-018 SATURATE=1: sum beyond representable range SHALL clamp to max/min of ACC_WIDTH (signed or unsigned per SIGNED) and set sat_hit.
REQ-019 Result chain per cycle: in_c_valid=1 -> out_c<=in_c, out_c_valid<=1 (upstream priority); else result_pending -> out_c<=result, out_c_valid<=1, result_pending<=0; else out_c_valid<=0, out_c holds value.
REQ-020 Minimum latency: in_last sampled in cycle T -> out_c_valid high in cycle T+MUL_LAT+1, for exactly one cycle, when in_c_valid low.
REQ-021 New result completing while result_pending=1 and not emitted that cycle SHALL be dropped, old result kept, err_ovf set.
REQ-022 Result completing in the same cycle the pending one is emitted SHALL be accepted (no overflow).
REQ-023 busy SHALL be high while any pipeline stage valid, state=ACCUM, or result_pending.
REQ-024 sat_hit and err_ovf SHALL clear only on reset.

Reset
REQ-025 When reset=0 at a rising edge: all outputs 0, acc=0, result=0, result_pending=0, all pipeline valids 0, state IDLE.
REQ-026 Reset mid-tile SHALL discard in-flight products and partial sum; no out_c_valid for that tile after release.
REQ-027 First in_valid SHALL be accepted in the first cycle after reset returns high.

Structure
REQ-028 Shared package pe_pkg SHALL hold state encoding (IDLE, ACCUM) and saturation-bound helper constants/functions.
REQ-029 Multiplier pipeline SHALL be sub-module pe_mult_pipe (parameters WIDTH, MUL_LAT, SIGNED; carries valid/last tags).
REQ-030 Implementation SHALL be 120-400 lines RTL, no vendor IP.

Verification (WIDTH=16, ACC_WIDTH=40, MUL_LAT=2 unless stated)
REQ-031 Signed tile (2,3),(4,5),(-1,7), last on third, cycle T -> out_c=19, out_c_valid only in cycle T+3; out_a/out_b echo inputs 1 cycle late.
REQ-032 Back-to-back tiles (1,1)last,(2,2)last on consecutive cycles -> out_c=1 then 4 on consecutive cycles, err_ovf=0.
REQ-033 in_c_valid=1, in_c=0xAA for 3 cycles covering local result 19 -> out_c 0xAA x3 then 19; err_ovf=0.
REQ-034 SATURATE=1, ACC_WIDTH=32: (0x7FFF,0x7FFF) x3 -> out_c=0x7FFFFFFF, sat_hit=1; SATURATE=0 same stimulus -> 0xBFFD0003.
REQ-035 in_c_valid held high, two local tiles complete -> first result emitted after in_c_valid drops, second dropped, err_ovf=1.
REQ-036 Reset=0 for 1 cycle between 2nd and 3rd operand of open tile -> no out_c_valid, busy=0 next cycle; new tile (3,3)last -> out_c=9.
